// File: rtl/mc_sequencer.sv
// -----------------------------------------------------------------------------
// mc_sequencer
//
// Multi-cycle control sequencer for the 8-bit, 4-register CPU datapath.
// Fetches an instruction over a req/valid handshake, latches it in an internal
// IR and walks it through FETCH/DECODE/EXEC/MEM/WB, emitting one-cycle
// datapath strobes. Run/single-step inputs allow stepping on the board.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   run         level: execute instructions back-to-back while high
//   step        pulse: execute exactly one instruction when idle
//   imem_valid  instruction memory presents a valid word this cycle
//   instr       instruction word, sampled only in FETCH with imem_valid
//   imem_req    fetch request, high in every FETCH cycle
//   ir          latched instruction register
//   pc_we       PC update strobe, one cycle per retired instruction
//   pc_src      0 = PC+1, 1 = PC+1+sext(ir[1:0]); meaningful with pc_we
//   reg_write, reg_dst, alu_src, alu_op,
//   mem_read, mem_write, mem_to_reg   datapath strobes
//   state       IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=7
//   busy        high in every state except IDLE and FAULT
//   fault       fetch timeout occurred; cleared only by reset
//   retired     count of completed instructions, wraps to 0
// -----------------------------------------------------------------------------
module mc_sequencer #(
   parameter int unsigned FETCH_TIMEOUT = 15,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             imem_valid,
   input  logic [7:0]       instr,
   output logic             imem_req,
   output logic [7:0]       ir,
   output logic             pc_we,
   output logic             pc_src,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             alu_src,
   output logic             alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic [2:0]       state,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_LW  = 2'b01,
      OP_SW  = 2'b10,
      OP_J   = 2'b11
   } opcode_t;

   // Last FETCH cycle count before giving up: the FAULT transition happens on
   // the FETCH_TIMEOUT-th consecutive cycle without imem_valid.
   localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t     st;
   opcode_t    op;
   logic [7:0] tmo_cnt;
   logic       single_step;

   assign op    = opcode_t'(ir[7:6]);
   assign state = st;
   assign busy  = (st != S_IDLE) && (st != S_FAULT);
   assign fault = (st == S_FAULT);

   // Strobes depend only on the registered state and IR, never on live inputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned
      // and infers a latch.
      imem_req   = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      case (st)
         S_FETCH: imem_req = 1'b1;
         S_EXEC: begin
            alu_src = (op == OP_LW) || (op == OP_SW);
            if (op == OP_J) begin
               pc_we  = 1'b1;
               pc_src = 1'b1;
            end
         end
         S_MEM: begin
            alu_src = 1'b1;
            if (op == OP_LW) begin
               mem_read = 1'b1;
            end else if (op == OP_SW) begin
               mem_write = 1'b1;
               pc_we     = 1'b1;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_we     = 1'b1;
            if (op == OP_ADD) begin
               reg_dst = 1'b1;
            end else if (op == OP_LW) begin
               mem_to_reg = 1'b1;
               mem_read   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         st          <= S_IDLE;
         ir          <= 8'd0;
         tmo_cnt     <= 8'd0;
         single_step <= 1'b0;
         retired     <= '0;
      end else begin
         case (st)
            S_IDLE: begin
               if (run) begin
                  st          <= S_FETCH;
                  single_step <= 1'b0;
               end else if (step) begin
                  st          <= S_FETCH;
                  single_step <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_valid) begin
                  ir      <= instr;
                  tmo_cnt <= 8'd0;
                  st      <= S_DECODE;
               end else if (tmo_cnt == TMO_LAST) begin
                  st <= S_FAULT;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_DECODE: st <= S_EXEC;
            S_EXEC: begin
               if (op == OP_ADD) begin
                  st <= S_WB;
               end else if (op != OP_J) begin
                  st <= S_MEM;
               end
            end
            S_MEM: begin
               if (op == OP_LW) begin
                  st <= S_WB;
               end
            end
            S_WB:    ;
            S_FAULT: ;
            default: st <= S_IDLE;
         endcase

         // The pc_we cycle is the retire point. This later assignment to st
         // overrides whatever the case above chose for EXEC/MEM/WB.
         if (pc_we) begin
            retired <= retired + CNT_W'(1);
            if (run && !single_step) begin
               st <= S_FETCH;
            end else begin
               st          <= S_IDLE;
               single_step <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc_sequencer
//
// Directed bench for mc_sequencer. Each instruction's expected per-cycle
// trace (state, strobes, busy, fault, ir, retired) is built from small
// per-opcode tables and pushed to a scoreboard queue; entries are popped and
// compared on every falling clock edge while inputs are driven.
// -----------------------------------------------------------------------------
module tb_mc_sequencer;

   // Strobe vector layout: {imem_req, pc_we, pc_src, reg_write, reg_dst,
   //                        alu_src, alu_op, mem_read, mem_write, mem_to_reg}
   localparam logic [9:0] NONE  = 10'b00_0000_0000;
   localparam logic [9:0] IREQ  = 10'b10_0000_0000;
   localparam logic [9:0] PCWE  = 10'b01_0000_0000;
   localparam logic [9:0] PCSRC = 10'b00_1000_0000;
   localparam logic [9:0] REGW  = 10'b00_0100_0000;
   localparam logic [9:0] RDST  = 10'b00_0010_0000;
   localparam logic [9:0] ASRC  = 10'b00_0001_0000;
   localparam logic [9:0] MRD   = 10'b00_0000_0100;
   localparam logic [9:0] MWR   = 10'b00_0000_0010;
   localparam logic [9:0] MTR   = 10'b00_0000_0001;

   typedef struct packed {
      logic [2:0] st;
      logic [9:0] strb;
      logic       busy;
      logic       fault;
      logic [7:0] ir;
      logic [7:0] ret;
   } obs_t;

   logic       clk;
   logic       reset;
   logic       run;
   logic       step;
   logic       imem_valid;
   logic [7:0] instr;
   logic       imem_req;
   logic [7:0] ir;
   logic       pc_we;
   logic       pc_src;
   logic       reg_write;
   logic       reg_dst;
   logic       alu_src;
   logic       alu_op;
   logic       mem_read;
   logic       mem_write;
   logic       mem_to_reg;
   logic [2:0] state;
   logic       busy;
   logic       fault;
   logic [7:0] retired;

   obs_t       q[$];
   logic [7:0] cur_ir;
   logic [7:0] cur_ret;
   int         vectors;
   int         miscompares;

   mc_sequencer #(
      .FETCH_TIMEOUT(15),
      .CNT_W        (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .step       (step),
      .imem_valid (imem_valid),
      .instr      (instr),
      .imem_req   (imem_req),
      .ir         (ir),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .alu_src    (alu_src),
      .alu_op     (alu_op),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .state      (state),
      .busy       (busy),
      .fault      (fault),
      .retired    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input logic [2:0] s, input logic [9:0] strb);
      obs_t e;
      e.st    = s;
      e.strb  = strb;
      e.busy  = (s != 3'd0) && (s != 3'd7);
      e.fault = (s == 3'd7);
      e.ir    = cur_ir;
      e.ret   = cur_ret;
      q.push_back(e);
   endtask

   // Sample on the falling edge, away from the active edge.
   task automatic pop_check(input string tag);
      obs_t o;
      obs_t e;
      @(negedge clk);
      vectors++;
      o = '{st: state,
            strb: {imem_req, pc_we, pc_src, reg_write, reg_dst,
                   alu_src, alu_op, mem_read, mem_write, mem_to_reg},
            busy: busy, fault: fault, ir: ir, ret: retired};
      if (q.size() == 0) begin
         miscompares++;
         $error("FAIL %s: observed %h but scoreboard empty", tag, o);
      end else begin
         e = q.pop_front();
         assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed st=%0d strb=%b busy=%b fault=%b ir=%h ret=%0d, expected st=%0d strb=%b busy=%b fault=%b ir=%h ret=%0d",
                   tag, o.st, o.strb, o.busy, o.fault, o.ir, o.ret,
                   e.st, e.strb, e.busy, e.fault, e.ir, e.ret);
         end
      end
   endtask

   // Runs one instruction starting in FETCH. delay = FETCH cycles without
   // imem_valid; poke drives step and imem_valid (with junk) during DECODE;
   // drop_run lowers run after EXEC; abort_at >= 0 stops before that cycle.
   task automatic do_instr(input logic [7:0] ins, input int delay,
                           input bit poke, input bit drop_run,
                           input int abort_at, input string tag);
      int n;
      for (int d = 0; d <= delay; d++) push_exp(3'd1, IREQ);
      cur_ir = ins;
      push_exp(3'd2, NONE);
      case (ins[7:6])
         2'b00: begin
            push_exp(3'd3, NONE);
            push_exp(3'd5, REGW | PCWE | RDST);
         end
         2'b01: begin
            push_exp(3'd3, ASRC);
            push_exp(3'd4, ASRC | MRD);
            push_exp(3'd5, REGW | PCWE | MTR | MRD);
         end
         2'b10: begin
            push_exp(3'd3, ASRC);
            push_exp(3'd4, ASRC | MWR | PCWE);
         end
         default: push_exp(3'd3, PCWE | PCSRC);
      endcase
      n = q.size();
      for (int i = 0; i < n; i++) begin
         if (abort_at >= 0 && i == abort_at) begin
            q.delete();
            return;
         end
         pop_check(tag);
         imem_valid = (i == delay) || (poke && i == delay + 1);
         instr      = (i == delay) ? ins : 8'($urandom);
         step       = poke && (i == delay + 1);
         if (drop_run && i == delay + 2) run = 1'b0;
      end
      cur_ret = cur_ret + 8'd1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cur_ir      = 8'd0;
      cur_ret     = 8'd0;
      reset       = 1'b1;
      run         = 1'b0;
      step        = 1'b0;
      imem_valid  = 1'b0;
      instr       = 8'd0;
      repeat (2) @(posedge clk);

      // Reset state, held and released.
      push_exp(3'd0, NONE);
      pop_check("reset_hold");
      reset = 1'b0;
      push_exp(3'd0, NONE);
      pop_check("reset_idle");

      // Single-step ADD; a step + junk valid during DECODE must be ignored.
      step = 1'b1;
      do_instr(8'b00_01_10_11, 0, 1'b1, 1'b0, -1, "step_add");
      push_exp(3'd0, NONE);
      pop_check("step_add_idle");

      // Run mode: LW, J with two-cycle fetch delay, SW, then ADD dropping run.
      run = 1'b1;
      do_instr(8'b01_00_01_10, 0, 1'b0, 1'b0, -1, "run_lw");
      do_instr(8'b11_0000_10,  2, 1'b0, 1'b0, -1, "run_j");
      do_instr(8'b10_00_01_01, 0, 1'b0, 1'b0, -1, "run_sw");
      do_instr(8'b00_11_00_01, 0, 1'b0, 1'b1, -1, "drop_run_add");
      push_exp(3'd0, NONE);
      pop_check("drop_run_idle");

      // Reset while SW is heading into MEM: no mem_write, IDLE, counters cleared.
      run = 1'b1;
      do_instr(8'b10_00_01_01, 0, 1'b0, 1'b0, 3, "rst_sw");
      reset   = 1'b1;
      cur_ir  = 8'd0;
      cur_ret = 8'd0;
      push_exp(3'd0, NONE);
      pop_check("rst_sw_idle");
      reset = 1'b0;
      run   = 1'b0;
      push_exp(3'd0, NONE);
      pop_check("rst_sw_released");

      // Fetch timeout: 15 FETCH cycles without valid, then sticky FAULT.
      step = 1'b1;
      for (int i = 0; i < 15; i++) push_exp(3'd1, IREQ);
      push_exp(3'd7, NONE);
      for (int i = 0; i < 16; i++) begin
         pop_check("timeout");
         step       = 1'b0;
         imem_valid = 1'b0;
      end
      for (int i = 0; i < 4; i++) push_exp(3'd7, NONE);
      for (int i = 0; i < 4; i++) begin
         run        = 1'b1;
         step       = i[0];
         imem_valid = 1'b1;
         instr      = 8'($urandom);
         pop_check("fault_sticky");
      end
      reset = 1'b1;
      push_exp(3'd0, NONE);
      pop_check("fault_reset");
      reset      = 1'b0;
      run        = 1'b0;
      step       = 1'b0;
      imem_valid = 1'b0;
      push_exp(3'd0, NONE);
      pop_check("fault_cleared");

      // 256 back-to-back ADDs wrap retired to 0; run drops in the last EXEC.
      run = 1'b1;
      for (int k = 0; k < 256; k++) begin
         do_instr({2'b00, 6'(k)}, 0, 1'b0, (k == 255), -1, "wrap_add");
      end
      push_exp(3'd0, NONE);
      pop_check("wrap_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
